// File: rtl/lsm_sequencer.sv
// lsm_sequencer: walks an 8-bit register mask from R0 to R7 and issues one
// single-cycle access per selected register on the shared data-memory port.
// Loads write memory data into the register file; stores write register
// data out to memory. Addresses increment once per access from the base.
module lsm_sequencer (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_start,
  input  logic        i_is_store,
  input  logic [15:0] i_base_addr,
  input  logic [7:0]  i_reg_mask,
  output logic        o_busy,
  output logic        o_done,
  output logic [3:0]  o_xfer_count,
  output logic [15:0] o_mem_address,
  output logic [15:0] o_mem_wrdata,
  output logic        o_mem_read,
  output logic        o_mem_write,
  input  logic [15:0] i_mem_dataout,
  output logic [2:0]  o_rf_rd_sel,
  input  logic [15:0] i_rf_rd_data,
  output logic        o_rf_wr_en,
  output logic [2:0]  o_rf_wr_sel,
  output logic [15:0] o_rf_wr_data
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_XFER = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t      r_state;
  state_t      w_state_next;
  logic [15:0] r_addr;
  logic [7:0]  r_mask;
  logic        r_store;
  logic [3:0]  r_count;
  logic [2:0]  w_idx;
  logic [7:0]  w_mask_cleared;

  // Lowest set bit of the remaining mask, and the mask with that bit removed.
  always_comb begin
    // NOTE: assign a default before any conditional update so no latch is inferred.
    w_idx = 3'd0;
    // Scan downward so the last match (the lowest index) wins.
    for (int i = 7; i >= 0; i--) begin
      if (r_mask[i]) w_idx = 3'(i);
    end
    w_mask_cleared = r_mask & ~(8'd1 << w_idx);
  end

  // Next-state decode.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE: if (i_start) w_state_next = (i_reg_mask != 8'd0) ? S_XFER : S_DONE;
      S_XFER: if (w_mask_cleared == 8'd0) w_state_next = S_DONE;
      S_DONE: w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  // State register plus operation context: address, remaining mask, mode, count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_addr  <= 16'd0;
      r_mask  <= 8'd0;
      r_store <= 1'b0;
      r_count <= 4'd0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      r_state <= w_state_next;
      case (r_state)
        S_IDLE: begin
          if (i_start) begin
            r_addr  <= i_base_addr;
            r_mask  <= i_reg_mask;
            r_store <= i_is_store;
            r_count <= 4'd0;
          end
        end
        S_XFER: begin
          r_mask  <= w_mask_cleared;
          r_addr  <= r_addr + 16'd1;
          r_count <= r_count + 4'd1;
        end
        default: ;
      endcase
    end
  end

  // Port outputs decoded from state; everything idles at zero outside XFER,
  // which also makes reset drop the strobes asynchronously.
  always_comb begin
    o_busy        = (r_state != S_IDLE);
    o_done        = (r_state == S_DONE);
    o_xfer_count  = r_count;
    o_mem_address = 16'd0;
    o_mem_wrdata  = 16'd0;
    o_mem_read    = 1'b0;
    o_mem_write   = 1'b0;
    o_rf_rd_sel   = 3'd0;
    o_rf_wr_en    = 1'b0;
    o_rf_wr_sel   = 3'd0;
    o_rf_wr_data  = 16'd0;
    if (r_state == S_XFER) begin
      o_mem_address = r_addr;
      if (r_store) begin
        o_rf_rd_sel  = w_idx;
        o_mem_wrdata = i_rf_rd_data;
        o_mem_write  = 1'b1;
      end else begin
        o_mem_read   = 1'b1;
        o_rf_wr_en   = 1'b1;
        o_rf_wr_sel  = w_idx;
        o_rf_wr_data = i_mem_dataout;
      end
    end
  end

endmodule
